channel_model_mc: RTL

Multi-lane behavioural/synthesizable channel model for RX bring-up. Each lane integrates its serial input into a saturating level with programmable rise and fall slopes, which models RC fading and ISI. A hysteresis comparator slices the level back to a bit, and an edge counter records each sliced-output transition. The block sits between the TX serializer model and the RX CDR/deserializer in RX testbenches and emulation builds.

---
 rtl/channel_model_mc_pkg.sv | 30 +++
 rtl/channel_model_mc_if.sv | 32 +++
 rtl/channel_model_mc_lane.sv | 110 +++++++++++
 rtl/channel_model_mc.sv | 60 ++++++
 4 files changed

// File: rtl/channel_model_mc_pkg.sv
// Shared constants and saturating arithmetic for the multi-lane channel model.
// Optional noise injection is enabled by defining CHANNEL_NOISE_EN.
package channel_pkg;

  localparam logic [15:0] CHAN_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] CHAN_LFSR_POLY = 16'hB400;

  // One bit wider than the widest supported level (16 bits) so sums never wrap.
  localparam int CHAN_ARITH_W = 17;

  // dir=1 adds and clamps at 2**level_w-1; dir=0 subtracts and clamps at 0.
  function automatic logic [CHAN_ARITH_W-1:0] sat_add_sub(
    input logic [CHAN_ARITH_W-1:0] level,
    input logic [CHAN_ARITH_W-1:0] step,
    input logic                    dir,
    input int                      level_w
  );
    logic [CHAN_ARITH_W-1:0] max_v;
    logic [CHAN_ARITH_W-1:0] res;
    max_v = (CHAN_ARITH_W'(1) << level_w) - CHAN_ARITH_W'(1);
    if (dir) begin
      res = level + step;
      if (res > max_v) res = max_v;
    end else begin
      res = (level >= step) ? (level - step) : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/channel_model_mc_if.sv
// Control/status bundle of the channel model; the DUT side uses the slave modport.
interface channel_model_mc_if #(
  parameter int NUM_LANES = 4,
  parameter int LEVEL_W   = 8,
  parameter int STEP_W    = 4,
  parameter int CNT_W     = 16
);

  logic                           en;
  logic [NUM_LANES-1:0]           in_bits;
  logic [STEP_W-1:0]              rise_step;
  logic [STEP_W-1:0]              fall_step;
  logic [LEVEL_W-1:0]             thresh_hi;
  logic [LEVEL_W-1:0]             thresh_lo;
  logic                           cnt_clr;
  logic [NUM_LANES-1:0]           out_bits;
  logic [NUM_LANES*LEVEL_W-1:0]   level;
  logic [NUM_LANES-1:0]           sat_hi;
  logic [NUM_LANES-1:0]           sat_lo;
  logic [NUM_LANES*CNT_W-1:0]     edge_cnt;

  modport master (
    output en, in_bits, rise_step, fall_step, thresh_hi, thresh_lo, cnt_clr,
    input  out_bits, level, sat_hi, sat_lo, edge_cnt
  );

  modport slave (
    input  en, in_bits, rise_step, fall_step, thresh_hi, thresh_lo, cnt_clr,
    output out_bits, level, sat_hi, sat_lo, edge_cnt
  );

endinterface

// File: rtl/channel_model_mc_lane.sv
// One channel lane: saturating integrator, hysteresis slicer, edge counter.
// Defining CHANNEL_NOISE_EN adds a per-lane LFSR whose noise perturbs only the slicer input.
module channel_lane
  import channel_pkg::*;
#(
  parameter int LEVEL_W = 8,
  parameter int STEP_W  = 4,
  parameter int CNT_W   = 16
`ifdef CHANNEL_NOISE_EN
  ,
  parameter int NOISE_W = 3,
  parameter int LANE    = 0
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_bit,
  input  logic [STEP_W-1:0]  rise_step,
  input  logic [STEP_W-1:0]  fall_step,
  input  logic [LEVEL_W-1:0] thresh_hi,
  input  logic [LEVEL_W-1:0] thresh_lo,
  input  logic               cnt_clr,
  output logic               out_bit,
  output logic [LEVEL_W-1:0] level,
  output logic               sat_hi,
  output logic               sat_lo,
  output logic [CNT_W-1:0]   edge_cnt
);

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [LEVEL_W-1:0] cmp;
  logic [LEVEL_W-1:0] lo_eff;
  logic               out_q;
  logic               out_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  always_comb begin
    level_d = level_q;
    if (en) begin
      level_d = LEVEL_W'(sat_add_sub(CHAN_ARITH_W'(level_q),
                                     in_bit ? CHAN_ARITH_W'(rise_step) : CHAN_ARITH_W'(fall_step),
                                     in_bit, LEVEL_W));
    end
  end

`ifdef CHANNEL_NOISE_EN
  logic [15:0]        lfsr_q;
  logic [NOISE_W-1:0] noise_raw;
  logic [NOISE_W-1:0] noise_mag;

  // Low LFSR bits are a two's-complement offset; apply it as a clamped add or subtract.
  assign noise_raw = lfsr_q[NOISE_W-1:0];
  assign noise_mag = noise_raw[NOISE_W-1] ? (~noise_raw + NOISE_W'(1)) : noise_raw;
  assign cmp = LEVEL_W'(sat_add_sub(CHAN_ARITH_W'(level_q), CHAN_ARITH_W'(noise_mag),
                                    ~noise_raw[NOISE_W-1], LEVEL_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= CHAN_LFSR_SEED ^ 16'(LANE + 1);
    end else if (en) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ CHAN_LFSR_POLY) : (lfsr_q >> 1);
    end
  end
`else
  assign cmp = level_q;
`endif

  // A low threshold above the high one collapses to a single threshold at hi.
  assign lo_eff = (thresh_lo < thresh_hi) ? thresh_lo : thresh_hi;

  always_comb begin
    out_d = out_q;
    if (!out_q && (cmp > thresh_hi)) begin
      out_d = 1'b1;
    end else if (out_q && (cmp < lo_eff)) begin
      out_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((out_d != out_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_bit  = out_q;
  assign level    = level_q;
  assign edge_cnt = cnt_q;
  assign sat_hi   = (level_q == '1);
  assign sat_lo   = (level_q == '0);

endmodule

// File: rtl/channel_model_mc.sv
// Multi-lane channel model top: one channel_lane per lane, packed onto the interface buses.
// Noise injection is compiled in when CHANNEL_NOISE_EN is defined.
module channel_model_mc
  import channel_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LEVEL_W   = 8,
  parameter int STEP_W    = 4,
  parameter int CNT_W     = 16
`ifdef CHANNEL_NOISE_EN
  ,
  parameter int NOISE_W   = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  channel_model_mc_if.slave bus
);

  logic [NUM_LANES-1:0]         out_v;
  logic [NUM_LANES-1:0]         sat_hi_v;
  logic [NUM_LANES-1:0]         sat_lo_v;
  logic [NUM_LANES*LEVEL_W-1:0] level_v;
  logic [NUM_LANES*CNT_W-1:0]   cnt_v;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    channel_lane #(
      .LEVEL_W (LEVEL_W),
      .STEP_W  (STEP_W),
      .CNT_W   (CNT_W)
`ifdef CHANNEL_NOISE_EN
      ,
      .NOISE_W (NOISE_W),
      .LANE    (i)
`endif
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.en),
      .in_bit    (bus.in_bits[i]),
      .rise_step (bus.rise_step),
      .fall_step (bus.fall_step),
      .thresh_hi (bus.thresh_hi),
      .thresh_lo (bus.thresh_lo),
      .cnt_clr   (bus.cnt_clr),
      .out_bit   (out_v[i]),
      .level     (level_v[i*LEVEL_W +: LEVEL_W]),
      .sat_hi    (sat_hi_v[i]),
      .sat_lo    (sat_lo_v[i]),
      .edge_cnt  (cnt_v[i*CNT_W +: CNT_W])
    );
  end

  assign bus.out_bits = out_v;
  assign bus.level    = level_v;
  assign bus.sat_hi   = sat_hi_v;
  assign bus.sat_lo   = sat_lo_v;
  assign bus.edge_cnt = cnt_v;

endmodule
